// File: rtl/univ_shift_reg_pkg.sv
// Shared definitions for the universal shift register: mode encodings and
// the counter-width helper used by the top, the interface and the framing counter.
package univ_shift_reg_pkg;

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_SHL  = 3'b001;
    localparam logic [2:0] MODE_SHR  = 3'b010;
    localparam logic [2:0] MODE_LOAD = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_ROR  = 3'b101;

    // Never returns 0, so a WIDTH=2 register still gets a one-bit counter.
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/univ_shift_reg_if.sv
// Control/data bundle between a serial source or controller (master) and the
// shift register (slave). cnt exposes the framing position for status readback.
interface univ_shift_reg_if
    import univ_shift_reg_pkg::*;
#(
    parameter int WIDTH = 8
) ();

    localparam int CNT_W = cnt_width(WIDTH);

    logic             en;
    logic             clr;
    logic [2:0]       mode;
    logic             din;
    logic [WIDTH-1:0] pdin;
    logic [WIDTH-1:0] q;
    logic             so_msb;
    logic             so_lsb;
    logic             word_valid;
    logic [CNT_W-1:0] cnt;

    modport master (
        output en, clr, mode, din, pdin,
        input  q, so_msb, so_lsb, word_valid, cnt
    );

    modport slave (
        input  en, clr, mode, din, pdin,
        output q, so_msb, so_lsb, word_valid, cnt
    );

endinterface

// File: rtl/univ_shift_reg_shift_word_counter.sv
// Serial framing counter: counts shift strobes and pulses word_valid on the
// edge that completes a WIDTH-bit word. A load strobe discards a partial word.
module shift_word_counter
    import univ_shift_reg_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int CNT_W = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rs,
    input  logic             clr,
    input  logic             shift_stb,
    input  logic             load_stb,
    output logic [CNT_W-1:0] cnt,
    output logic             word_valid
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    always_ff @(posedge clk) begin
        if (!rs) begin
            cnt        <= '0;
            word_valid <= 1'b0;
        end else if (clr) begin
            cnt        <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            if (load_stb) begin
                cnt <= '0;
            end else if (shift_stb) begin
                // Explicit wrap keeps non-power-of-two widths framed correctly.
                if (cnt == CNT_LAST) begin
                    cnt        <= '0;
                    word_valid <= 1'b1;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/univ_shift_reg.sv
// Parametrised universal shift register: shift left/right, rotate, parallel
// load and serial word framing between serial sources and parallel consumers.
module univ_shift_reg
    import univ_shift_reg_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input logic                clk,
    input logic                rs,
    univ_shift_reg_if.slave    bus
);

    localparam int CNT_W = cnt_width(WIDTH);

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_next;
    logic             shift_stb;
    logic             load_stb;
    logic [CNT_W-1:0] cnt;
    logic             word_valid;

    always_comb begin
        q_next = q_r;
        unique case (bus.mode)
            MODE_SHL:  q_next = {q_r[WIDTH-2:0], bus.din};
            MODE_SHR:  q_next = {bus.din, q_r[WIDTH-1:1]};
            MODE_LOAD: q_next = bus.pdin;
            MODE_ROL:  q_next = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
            MODE_ROR:  q_next = {q_r[0], q_r[WIDTH-1:1]};
            default:   q_next = q_r;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rs) begin
            q_r <= RST_VAL;
        end else if (bus.clr) begin
            q_r <= RST_VAL;
        end else if (bus.en) begin
            q_r <= q_next;
        end
    end

    assign shift_stb = bus.en && ((bus.mode == MODE_SHL) || (bus.mode == MODE_SHR));
    assign load_stb  = bus.en && (bus.mode == MODE_LOAD);

    shift_word_counter #(
        .WIDTH (WIDTH)
    ) u_counter (
        .clk        (clk),
        .rs         (rs),
        .clr        (bus.clr),
        .shift_stb  (shift_stb),
        .load_stb   (load_stb),
        .cnt        (cnt),
        .word_valid (word_valid)
    );

    assign bus.q          = q_r;
    assign bus.so_msb     = q_r[WIDTH-1];
    assign bus.so_lsb     = q_r[0];
    assign bus.word_valid = word_valid;
    assign bus.cnt        = cnt;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg (WIDTH=8): directed scenarios plus random traffic,
// checked every cycle against an arithmetic reference model.
module tb_univ_shift_reg;
    import univ_shift_reg_pkg::*;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rs  = 1'b0;

    univ_shift_reg_if #(.WIDTH(W)) bus ();

    univ_shift_reg #(.WIDTH(W), .RST_VAL(8'h00)) dut (
        .clk (clk),
        .rs  (rs),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: register value and number of shifts since the last
    // reset/clear/load; a word completes whenever that count is a multiple of W.
    int unsigned m_q   = 0;
    int          m_run = 0;
    bit          m_wv  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit r, input bit c, input bit e,
                              input bit [2:0] m, input bit d, input bit [7:0] p);
        m_wv = 1'b0;
        if (!r || c) begin
            m_q   = 0;
            m_run = 0;
        end else if (e) begin
            case (m)
                3'd1: begin m_q = ((m_q * 2) + d) % 256;          m_run++; m_wv = (m_run % W == 0); end
                3'd2: begin m_q = (m_q / 2) + (d ? 128 : 0);      m_run++; m_wv = (m_run % W == 0); end
                3'd3: begin m_q = p; m_run = 0; end
                3'd4: m_q = ((m_q * 2) % 256) + (m_q / 128);
                3'd5: m_q = (m_q / 2) + ((m_q % 2) * 128);
                default: ;
            endcase
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, " q"},      32'(bus.q),          32'(m_q));
        chk({tag, " wv"},     32'(bus.word_valid), 32'(m_wv));
        chk({tag, " so_msb"}, 32'(bus.so_msb),     32'(m_q / 128));
        chk({tag, " so_lsb"}, 32'(bus.so_lsb),     32'(m_q % 2));
        chk({tag, " cnt"},    32'(bus.cnt),        32'(m_run % W));
    endtask

    task automatic step(input bit r, input bit c, input bit e, input bit [2:0] m,
                        input bit d, input bit [7:0] p, input string tag);
        rs       = r;
        bus.clr  = c;
        bus.en   = e;
        bus.mode = m;
        bus.din  = d;
        bus.pdin = p;
        @(posedge clk);
        model_edge(r, c, e, m, d, p);
        #1;
        check_outputs(tag);
    endtask

    bit [7:0] pat;

    initial begin
        bus.clr = 1'b0; bus.en = 1'b0; bus.mode = MODE_HOLD; bus.din = 1'b0; bus.pdin = '0;

        step(0, 0, 0, MODE_HOLD, 0, 8'h00, "reset");
        step(0, 0, 1, MODE_LOAD, 0, 8'hFF, "reset_prio");
        chk("reset q zero", 32'(bus.q), 32'h00);

        // 1: a reset pulse between edges must not touch q
        step(1, 0, 1, MODE_LOAD, 0, 8'h5A, "t1_load");
        bus.en = 1'b0;
        #2 rs = 1'b0;
        #2 rs = 1'b1;
        @(posedge clk);
        model_edge(1, 0, 0, MODE_HOLD, 0, 8'h00);
        #1;
        chk("t1 glitch q", 32'(bus.q), 32'h5A);
        step(0, 0, 0, MODE_HOLD, 0, 8'h00, "t1_rst");
        chk("t1 rst q", 32'(bus.q), 32'h00);

        // 2: SHL 1,0,1,1,0,0,1,0
        pat = 8'b1011_0010;
        for (int i = 7; i >= 0; i--) begin
            step(1, 0, 1, MODE_SHL, pat[i], 8'h00, "t2_shl");
            if (i > 0) chk("t2 wv early", 32'(bus.word_valid), 32'h0);
        end
        chk("t2 q", 32'(bus.q), 32'hB2);
        chk("t2 wv", 32'(bus.word_valid), 32'h1);
        step(1, 0, 1, MODE_HOLD, 0, 8'h00, "t2_after");
        chk("t2 wv after", 32'(bus.word_valid), 32'h0);

        // 3: load and rotate
        step(1, 0, 1, MODE_LOAD, 0, 8'hA5, "t3_load");
        step(1, 0, 1, MODE_ROL, 0, 8'h00, "t3_rol");
        chk("t3 rol", 32'(bus.q), 32'h4B);
        step(1, 0, 1, MODE_ROR, 0, 8'h00, "t3_ror");
        chk("t3 ror", 32'(bus.q), 32'hA5);

        // 4: SHR ones from zero, then reserved mode holds
        step(1, 1, 0, MODE_HOLD, 0, 8'h00, "t4_clr");
        for (int i = 0; i < 3; i++) step(1, 0, 1, MODE_SHR, 1, 8'h00, "t4_shr");
        chk("t4 shr", 32'(bus.q), 32'hE0);
        for (int i = 0; i < 2; i++) step(1, 0, 1, 3'b111, 1, 8'hFF, "t4_rsvd");
        chk("t4 rsvd", 32'(bus.q), 32'hE0);

        // 5: partial word, stall, reset, then a full word
        step(1, 1, 0, MODE_HOLD, 0, 8'h00, "t5_clr");
        for (int i = 0; i < 5; i++) step(1, 0, 1, MODE_SHL, 1, 8'h00, "t5_shl");
        for (int i = 0; i < 3; i++) step(1, 0, 0, MODE_SHL, 0, 8'h00, "t5_stall");
        chk("t5 cnt hold", 32'(bus.cnt), 32'd5);
        step(0, 0, 1, MODE_SHL, 0, 8'h00, "t5_rst");
        for (int i = 0; i < 8; i++) step(1, 0, 1, MODE_SHL, i[0], 8'h00, "t5_word");
        chk("t5 wv", 32'(bus.word_valid), 32'h1);

        // 6: clear overrides disabled enable; load discards partial word
        step(1, 0, 1, MODE_LOAD, 0, 8'hFF, "t6_load");
        step(1, 1, 0, MODE_HOLD, 0, 8'h00, "t6_clr");
        chk("t6 clr", 32'(bus.q), 32'h00);
        for (int i = 0; i < 4; i++) step(1, 0, 1, MODE_SHR, 1, 8'h00, "t6_pre");
        step(1, 0, 1, MODE_LOAD, 0, 8'h3C, "t6_reload");
        for (int i = 0; i < 8; i++) step(1, 0, 1, MODE_SHR, 0, 8'h00, "t6_word");
        chk("t6 wv", 32'(bus.word_valid), 32'h1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 49) != 0), ($urandom_range(0, 29) == 0),
                 ($urandom_range(0, 4) != 0), 3'($urandom_range(0, 7)),
                 1'($urandom), 8'($urandom), "rand");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
- Parametrised universal shift register; successor to the team's fixed 8-bit serial-in LED shifter.
- Adds configurable width, a mode select and parallel load.
- Adds left/right shift, rotate, serial outputs and a bit counter that flags each completed serial word.
- Sits between serial sources (switch/pin deserialisers) and parallel consumers (LED banks, display/decode logic).

Parameters:
- WIDTH, 8, register width in bits (>= 2).
- RST_VAL, {WIDTH{1'b0}}, value loaded into q on reset and on clr.
- CNT_W, $clog2(WIDTH), localparam; width of the shift counter.

Ports:
- clk  input  1  rising-edge clock.
- rs  input  1  reset; synchronous, active-low.
- en  input  1  operation enable; when 0, the register and counter hold.
- clr  input  1  synchronous clear to RST_VAL, counter to 0.
- mode  input  3  operation select (encoding below).
- din  input  1  serial data in.
- pdin  input  WIDTH  parallel load data.
- q  output  WIDTH  register contents (drives LEDs).
- so_msb  output  1  q[WIDTH-1], combinational.
- so_lsb  output  1  q[0], combinational.
- word_valid  output  1  one-cycle pulse; WIDTH serial bits have been collected.

Behaviour:
- Reset and priority: single clock, one always block on posedge clk. Priority is rs==0 > clr==1 > en==1 > hold.
- rs==0 at an edge: q=RST_VAL, cnt=0, word_valid=0. rs low between edges has no effect until the next edge (no asynchronous path).
- clr==1 at an edge: q=RST_VAL, cnt=0, word_valid=0. clr acts regardless of en.
- en==0: q and cnt hold; word_valid=0.
- Mode encoding, evaluated when en==1:
  - 000 HOLD: q unchanged.
  - 001 SHL: q={q[WIDTH-2:0],din}.
  - 010 SHR: q={din,q[WIDTH-1:1]}.
  - 011 LOAD: q=pdin; cnt=0.
  - 100 ROL: q={q[WIDTH-2:0],q[WIDTH-1]}.
  - 101 ROR: q={q[0],q[WIDTH-1:1]}.
  - 110, 111: treated as HOLD; no X propagation.
- Counter:
  - Increments on every enabled SHL/SHR edge only.
  - HOLD, ROL, ROR leave cnt unchanged.
  - On the edge where cnt==WIDTH-1 and an SHL/SHR occurs: cnt wraps to 0 and word_valid is registered to 1.
  - word_valid is therefore high exactly in the cycle where q first holds the complete word.
  - On any other edge, word_valid=0. It is never high for two consecutive cycles unless WIDTH shifts occur back-to-back; it cannot for WIDTH>=2.
- Mixed directions: switching between SHL and SHR mid-word still counts every shift; no direction tracking.
- LOAD mid-word: discards the partial count; no word_valid.
- Latency: q updates one clock after inputs are sampled. so_msb/so_lsb follow q combinationally (zero added latency).
- Reset mid-operation: the next word needs a full WIDTH shifts.

Decomposition:
- Shared package holds:
  - the mode localparams MODE_HOLD, MODE_SHL, MODE_SHR, MODE_LOAD, MODE_ROL, MODE_ROR (3-bit);
  - the CNT_W helper function.
- Natural sub-module: shift_word_counter. It takes clk, rs, clr, a shift strobe and a load strobe, and emits cnt and word_valid. Keeps framing logic separately verifiable and reusable for wider deserialisers.
- The data path stays in univ_shift_reg.

Test Plan (WIDTH=8, RST_VAL=0):
1. Preload 0x5A, drop rs low mid-cycle, release before the edge -> q stays 0x5A. Hold rs low across an edge -> q=0x00, word_valid=0.
2. en=1, SHL, din 1,0,1,1,0,0,1,0 over 8 edges -> q=0xB2 after the 8th edge; word_valid=1 for exactly that cycle, 0 before and after.
3. LOAD pdin=0xA5, then ROL once -> 0x4B, then ROR once -> 0xA5. so_msb=1, so_lsb=1; word_valid stays 0 throughout.
4. From 0x00, SHR with din=1 for 3 edges -> q=0xE0, so_msb=1, so_lsb=0. mode=111 for 2 edges -> q unchanged.
5. SHL 5 bits, en=0 for 3 edges (q/cnt hold), rs=0 for one edge, then SHL 8 bits -> word_valid only after the 8th post-reset shift.
6. q=0xFF with en=0, clr=1 -> q=0x00 next edge. LOAD after 4 shifts then 8 shifts -> word_valid on the 8th post-load shift only.
